// File: rtl/dmem_ws.sv
// Data memory with a req/ack handshake, configurable wait states, byte enables
// and error reporting for misaligned or out-of-range byte addresses.
module dmem_ws #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned ADDR_W = 32,
    parameter int unsigned DEPTH  = 64,
    parameter int unsigned WAIT   = 2
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req,
    input  logic                we,
    input  logic [ADDR_W-1:0]   addr,
    input  logic [DATA_W-1:0]   wdata,
    input  logic [DATA_W/8-1:0] be,
    output logic [DATA_W-1:0]   rdata,
    output logic                ack,
    output logic                busy,
    output logic                err
);

    localparam int unsigned NB  = DATA_W / 8;
    localparam int unsigned OFS = $clog2(NB);
    localparam int unsigned IDX = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT == 0) ? 4'd0 : 4'(WAIT - 1);

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_t;

    state_t          state_q;
    logic [3:0]      cnt_q;
    logic            we_q;
    logic            bad_q;
    logic [IDX-1:0]  idx_q;
    logic [DATA_W-1:0] wdata_q;
    logic [NB-1:0]   be_q;
    logic            ack_q;
    logic            busy_q;
    logic            err_q;

    logic [DATA_W-1:0] mem [DEPTH];

    logic            bad_in;
    logic [IDX-1:0]  idx_in;

    // Decode the live request address; only used at the acceptance edge.
    always_comb begin
        idx_in = addr[OFS+IDX-1:OFS];
        bad_in = ((addr & ADDR_W'(NB - 1)) != '0) || ((addr >> (OFS + IDX)) != '0);
    end

    // Request capture, wait countdown and registered handshake outputs.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            we_q    <= 1'b0;
            bad_q   <= 1'b0;
            idx_q   <= '0;
            wdata_q <= '0;
            be_q    <= '0;
            ack_q   <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    ack_q <= 1'b0;
                    err_q <= 1'b0;
                    if (req) begin
                        we_q    <= we;
                        bad_q   <= bad_in;
                        idx_q   <= idx_in;
                        wdata_q <= wdata;
                        be_q    <= be;
                        busy_q  <= 1'b1;
                        if (WAIT == 0) begin
                            state_q <= StResp;
                            ack_q   <= 1'b1;
                            err_q   <= bad_in;
                        end else begin
                            state_q <= StWait;
                            cnt_q   <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt_q == 4'd0) begin
                        state_q <= StResp;
                        ack_q   <= 1'b1;
                        err_q   <= bad_q;
                    end else begin
                        cnt_q <= cnt_q - 4'd1;
                    end
                end
                StResp: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= StIdle;
                    ack_q   <= 1'b0;
                    err_q   <= 1'b0;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // Commit enabled bytes at the end of the response cycle of a good write.
    always_ff @(posedge clk) begin
        if (state_q == StResp && we_q && !bad_q) begin
            for (int i = 0; i < NB; i++) begin
                if (be_q[i]) begin
                    mem[idx_q][8*i +: 8] <= wdata_q[8*i +: 8];
                end
            end
        end
    end

    // Read data is driven only during a good read acknowledge.
    always_comb begin
        rdata = '0;
        if (ack_q && !we_q && !err_q) begin
            rdata = mem[idx_q];
        end
    end

    assign ack  = ack_q;
    assign busy = busy_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dmem_ws.sv
// Self-checking bench for dmem_ws: a WAIT=2 instance driven with directed and
// random accesses against a word-array model, and a WAIT=0 instance for
// back-to-back timing.
module tb_dmem_ws;

    localparam int unsigned WS    = 2;
    localparam int unsigned WORDS = 64;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;

    logic        req = 1'b0, we = 1'b0;
    logic [31:0] addr = '0, wdata = '0;
    logic [3:0]  be = '0;
    logic [31:0] rdata;
    logic        ack, busy, err;

    logic        req0 = 1'b0, we0 = 1'b0;
    logic [31:0] addr0 = '0, wdata0 = '0;
    logic [3:0]  be0 = '0;
    logic [31:0] rdata0;
    logic        ack0, busy0, err0;

    logic [31:0] model [WORDS];
    int          n_assert = 0;
    int          n_fail = 0;

    dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(WORDS), .WAIT(WS)) dut (
        .clk(clk), .reset(rst_n), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .be(be), .rdata(rdata), .ack(ack), .busy(busy), .err(err)
    );

    dmem_ws #(.DATA_W(32), .ADDR_W(32), .DEPTH(WORDS), .WAIT(0)) dut0 (
        .clk(clk), .reset(rst_n), .req(req0), .we(we0), .addr(addr0), .wdata(wdata0),
        .be(be0), .rdata(rdata0), .ack(ack0), .busy(busy0), .err(err0)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit is_bad(input logic [31:0] a);
        return (a % 4 != 0) || (a >= 4 * WORDS);
    endfunction

    // One full transaction on the WAIT=2 instance, checked against the model.
    task automatic access(input logic w, input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] b, input bit scramble);
        logic [31:0] exp_rd;
        bit          bad;
        int          lat;
        bad    = is_bad(a);
        exp_rd = (bad || w) ? 32'h0 : model[a / 4];
        @(negedge clk);
        req = 1'b1; we = w; addr = a; wdata = d; be = b;
        @(negedge clk);
        req = 1'b0;
        if (scramble) begin
            addr = $urandom; wdata = $urandom; be = 4'($urandom); we = ~w;
        end
        lat = 1;
        while (!ack && lat < 20) begin
            chk("busy_wait", {31'b0, busy}, 32'h1);
            @(negedge clk);
            lat++;
        end
        chk("latency", lat, WS + 1);
        chk("busy_ack", {31'b0, busy}, 32'h1);
        chk("err", {31'b0, err}, {31'b0, bad});
        if (!w) chk("rdata", rdata, exp_rd);
        if (w && !bad) begin
            for (int i = 0; i < 4; i++)
                if (b[i]) model[a / 4][8*i +: 8] = d[8*i +: 8];
        end
        @(negedge clk);
        chk("ack_drop", {31'b0, ack}, 32'h0);
        chk("busy_drop", {31'b0, busy}, 32'h0);
        chk("rdata_idle", rdata, 32'h0);
    endtask

    initial begin
        logic [31:0] a, v;
        bit          seen;

        // Reset state
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ack", {31'b0, ack}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_ack0", {31'b0, ack0}, 32'h0);
        rst_n = 1'b1;

        // Fill memory with known contents
        for (int i = 0; i < WORDS; i++) access(1'b1, 32'(i * 4), $urandom, 4'hF, 1'b0);

        // Write then read
        access(1'b1, 32'h08, 32'hDEADBEEF, 4'hF, 1'b0);
        access(1'b0, 32'h08, 32'h0, 4'h0, 1'b0);

        // Byte enables
        access(1'b1, 32'h0C, 32'h11223344, 4'hF, 1'b0);
        access(1'b1, 32'h0C, 32'hAABBCCDD, 4'b0101, 1'b0);
        access(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0);
        chk("be_merge", model[3], 32'h11BB33DD);
        access(1'b1, 32'h0C, 32'h55555555, 4'h0, 1'b0);
        access(1'b0, 32'h0C, 32'h0, 4'h0, 1'b0);

        // Errors; then confirm the whole array is untouched
        access(1'b0, 32'h06, 32'h0, 4'h0, 1'b0);
        access(1'b0, 32'h100, 32'h0, 4'h0, 1'b0);
        access(1'b1, 32'h100, 32'h12345678, 4'hF, 1'b0);
        access(1'b1, 32'h0A, 32'h12345678, 4'hF, 1'b0);
        for (int i = 0; i < WORDS; i++) access(1'b0, 32'(i * 4), 32'h0, 4'h0, 1'b0);

        // Input hold-off
        access(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, 1'b1);
        access(1'b0, 32'h20, 32'h0, 4'h0, 1'b1);

        // Random traffic
        for (int n = 0; n < 60; n++) begin
            case ($urandom_range(0, 9))
                0: a = 32'($urandom_range(0, WORDS - 1)) * 4 + 32'($urandom_range(1, 3));
                1: a = $urandom | 32'h100;
                default: a = 32'($urandom_range(0, WORDS - 1)) * 4;
            endcase
            access(1'($urandom), a, $urandom, 4'($urandom), 1'($urandom));
        end

        // Reset mid-write: old value must survive
        v = model[4];
        @(negedge clk);
        req = 1'b1; we = 1'b1; addr = 32'h10; wdata = ~v; be = 4'hF;
        @(negedge clk);
        req = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("abort_ack", {31'b0, ack}, 32'h0);
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_err", {31'b0, err}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (5) begin
            @(negedge clk);
            if (ack) seen = 1'b1;
        end
        chk("abort_no_ack", {31'b0, seen}, 32'h0);
        access(1'b0, 32'h10, 32'h0, 4'h0, 1'b0);

        // WAIT=0 instance: one write, then back-to-back reads with req held
        @(negedge clk);
        req0 = 1'b1; we0 = 1'b1; addr0 = 32'h04; wdata0 = 32'hA5A5_1234; be0 = 4'hF;
        @(negedge clk);
        req0 = 1'b0;
        chk("w0_ack", {31'b0, ack0}, 32'h1);
        chk("w0_err", {31'b0, err0}, 32'h0);
        chk("w0_busy", {31'b0, busy0}, 32'h1);
        @(negedge clk);
        chk("w0_ack_drop", {31'b0, ack0}, 32'h0);
        chk("w0_busy_drop", {31'b0, busy0}, 32'h0);
        req0 = 1'b1; we0 = 1'b0; addr0 = 32'h04;
        @(negedge clk);
        chk("b2b_ack1", {31'b0, ack0}, 32'h1);
        chk("b2b_rdata1", rdata0, 32'hA5A5_1234);
        @(negedge clk);
        chk("b2b_gap", {31'b0, ack0}, 32'h0);
        chk("b2b_gap_busy", {31'b0, busy0}, 32'h0);
        @(negedge clk);
        chk("b2b_ack2", {31'b0, ack0}, 32'h1);
        chk("b2b_rdata2", rdata0, 32'hA5A5_1234);
        req0 = 1'b0;
        @(negedge clk);
        chk("b2b_no_extra1", {31'b0, ack0}, 32'h0);
        @(negedge clk);
        chk("b2b_no_extra2", {31'b0, ack0}, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
